// File: rtl/stopwatch_if.sv
// Control and status bundle for the stopwatch; master drives pulses and limit, slave is the timer.
// With STOPWATCH_BCD_EN defined the bundle also carries the BCD digit outputs.
interface stopwatch_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       lap;
    logic [6:0] limit;
    logic [6:0] time_out;
    logic [6:0] lap_out;
    logic       running;
    logic       sec_tick;
    logic       done;
`ifdef STOPWATCH_BCD_EN
    logic [3:0] tens_out;
    logic [3:0] ones_out;

    modport master (
        output start, stop, clear, lap, limit,
        input  time_out, lap_out, running, sec_tick, done, tens_out, ones_out
    );
    modport slave (
        input  start, stop, clear, lap, limit,
        output time_out, lap_out, running, sec_tick, done, tens_out, ones_out
    );
`else
    modport master (
        output start, stop, clear, lap, limit,
        input  time_out, lap_out, running, sec_tick, done
    );
    modport slave (
        input  start, stop, clear, lap, limit,
        output time_out, lap_out, running, sec_tick, done
    );
`endif
endinterface

// File: rtl/stopwatch.sv
// Up-counting seconds timer with pause/resume, lap capture and a programmable stop limit.
// Define STOPWATCH_BCD_EN to add registered BCD digits (tens_out/ones_out) of time_out.
module stopwatch #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int MAX_SEC       = 99
) (
    input  logic clk,
    input  logic rst,
    stopwatch_if.slave sw
);
    localparam int             PW   = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0]  TERM = PW'(TICKS_PER_SEC - 1);
    localparam logic [6:0]     MAX7 = 7'(MAX_SEC);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        r_state, w_state_next;
    logic [PW-1:0] r_presc, w_presc_next;
    logic [6:0]    r_time,  w_time_next;
    logic [6:0]    r_lap;
    logic          r_tick,  w_tick_next;
    logic [6:0]    w_lim;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_presc <= '0;
            r_time  <= '0;
            r_lap   <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_presc <= w_presc_next;
            r_time  <= w_time_next;
            r_tick  <= w_tick_next;
            if (sw.lap)
                r_lap <= r_time;
        end
    end

    always_comb begin
        w_lim        = (sw.limit == 7'd0 || sw.limit > MAX7) ? MAX7 : sw.limit;
        w_state_next = r_state;
        w_presc_next = r_presc;
        w_time_next  = r_time;
        w_tick_next  = 1'b0;
        // clear zeroes the count in every state; the state change is decided below
        if (sw.clear) begin
            w_time_next  = '0;
            w_presc_next = '0;
        end
        case (r_state)
            S_IDLE: begin
                if (!sw.clear && sw.start)
                    w_state_next = S_RUN;
            end
            S_RUN: begin
                if (sw.stop) begin
                    w_state_next = S_PAUSE;
                end else if (sw.clear) begin
                    w_state_next = S_RUN;
                end else if (r_time >= w_lim) begin
                    w_state_next = S_DONE;
                end else if (r_presc == TERM) begin
                    w_presc_next = '0;
                    w_time_next  = r_time + 7'd1;
                    w_tick_next  = 1'b1;
                    if (r_time + 7'd1 == w_lim)
                        w_state_next = S_DONE;
                end else begin
                    w_presc_next = r_presc + PW'(1);
                end
            end
            S_PAUSE: begin
                if (sw.clear)
                    w_state_next = S_IDLE;
                else if (!sw.stop && sw.start)
                    w_state_next = S_RUN;
            end
            S_DONE: begin
                if (sw.clear)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    assign sw.time_out = r_time;
    assign sw.lap_out  = r_lap;
    assign sw.running  = (r_state == S_RUN);
    assign sw.sec_tick = r_tick;
    assign sw.done     = (r_state == S_DONE);

`ifdef STOPWATCH_BCD_EN
    logic [3:0] r_tens, r_ones, w_tens, w_ones;

    always_comb begin
        w_tens = 4'd9;
        w_ones = 4'd9;
        if (w_time_next <= 7'd99) begin
            w_tens = 4'(w_time_next / 7'd10);
            w_ones = 4'(w_time_next % 7'd10);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tens <= '0;
            r_ones <= '0;
        end else begin
            r_tens <= w_tens;
            r_ones <= w_ones;
        end
    end

    assign sw.tens_out = r_tens;
    assign sw.ones_out = r_ones;
`endif
endmodule

// File: tb/tb_stopwatch.sv
// Directed bench for stopwatch with TICKS_PER_SEC=4; BCD checks run when STOPWATCH_BCD_EN is defined.
module tb_stopwatch;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    stopwatch_if sw ();

    stopwatch #(.TICKS_PER_SEC(4), .MAX_SEC(99)) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 ns so outputs are sampled away from the edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        step(3);
        n_cmp++; if (sw.time_out !== 7'd0) begin n_bad++; $display("FAIL reset time_out: got %0d want 0", sw.time_out); end
        n_cmp++; if (sw.lap_out !== 7'd0) begin n_bad++; $display("FAIL reset lap_out: got %0d want 0", sw.lap_out); end
        n_cmp++; if (sw.running !== 1'b0) begin n_bad++; $display("FAIL reset running: got %b want 0", sw.running); end
        n_cmp++; if (sw.sec_tick !== 1'b0) begin n_bad++; $display("FAIL reset sec_tick: got %b want 0", sw.sec_tick); end
        n_cmp++; if (sw.done !== 1'b0) begin n_bad++; $display("FAIL reset done: got %b want 0", sw.done); end
        rst = 1'b1;
        step(1);
        $display("test_reset complete");
    endtask

    task automatic test_count;
        sw.start = 1'b1; step(1); sw.start = 1'b0;
        n_cmp++; if (sw.running !== 1'b1) begin n_bad++; $display("FAIL count running: got %b want 1", sw.running); end
        for (int k = 1; k <= 3; k++) begin
            step(3);
            n_cmp++; if (sw.time_out !== 7'(k - 1) || sw.sec_tick !== 1'b0) begin
                n_bad++; $display("FAIL count pre%0d: got time %0d tick %b want %0d/0", k, sw.time_out, sw.sec_tick, k - 1);
            end
            step(1);
            n_cmp++; if (sw.time_out !== 7'(k) || sw.sec_tick !== 1'b1) begin
                n_bad++; $display("FAIL count step%0d: got time %0d tick %b want %0d/1", k, sw.time_out, sw.sec_tick, k);
            end
        end
        $display("test_count complete");
    endtask

    task automatic test_pause;
        step(2);
        sw.stop = 1'b1; step(1); sw.stop = 1'b0;
        n_cmp++; if (sw.running !== 1'b0) begin n_bad++; $display("FAIL pause running: got %b want 0", sw.running); end
        step(20);
        n_cmp++; if (sw.time_out !== 7'd3) begin n_bad++; $display("FAIL pause frozen: got %0d want 3", sw.time_out); end
        sw.start = 1'b1; step(1); sw.start = 1'b0;
        step(1);
        n_cmp++; if (sw.time_out !== 7'd3) begin n_bad++; $display("FAIL resume early: got %0d want 3", sw.time_out); end
        step(1);
        n_cmp++; if (sw.time_out !== 7'd4 || sw.sec_tick !== 1'b1) begin
            n_bad++; $display("FAIL resume tick: got time %0d tick %b want 4/1", sw.time_out, sw.sec_tick);
        end
        sw.stop = 1'b1; step(1); sw.stop = 1'b0;
        sw.clear = 1'b1; step(1); sw.clear = 1'b0;
        n_cmp++; if (sw.time_out !== 7'd0 || sw.running !== 1'b0) begin
            n_bad++; $display("FAIL pause clear: got time %0d running %b want 0/0", sw.time_out, sw.running);
        end
        $display("test_pause complete");
    endtask

    task automatic test_limit;
        sw.limit = 7'd3;
        sw.start = 1'b1; step(1); sw.start = 1'b0;
        step(11);
        n_cmp++; if (sw.time_out !== 7'd2 || sw.done !== 1'b0) begin
            n_bad++; $display("FAIL limit pre: got time %0d done %b want 2/0", sw.time_out, sw.done);
        end
        step(1);
        n_cmp++; if (sw.time_out !== 7'd3 || sw.done !== 1'b1 || sw.running !== 1'b0 || sw.sec_tick !== 1'b1) begin
            n_bad++; $display("FAIL limit hit: got time %0d done %b run %b tick %b want 3/1/0/1", sw.time_out, sw.done, sw.running, sw.sec_tick);
        end
        sw.start = 1'b1; step(1); sw.start = 1'b0;
        step(8);
        n_cmp++; if (sw.time_out !== 7'd3 || sw.done !== 1'b1 || sw.running !== 1'b0) begin
            n_bad++; $display("FAIL limit hold: got time %0d done %b run %b want 3/1/0", sw.time_out, sw.done, sw.running);
        end
        sw.clear = 1'b1; step(1); sw.clear = 1'b0;
        step(4);
        n_cmp++; if (sw.time_out !== 7'd0 || sw.done !== 1'b0 || sw.running !== 1'b0) begin
            n_bad++; $display("FAIL limit clear: got time %0d done %b run %b want 0/0/0", sw.time_out, sw.done, sw.running);
        end
        sw.limit = 7'd0;
        $display("test_limit complete");
    endtask

    task automatic test_lap;
        sw.start = 1'b1; step(1); sw.start = 1'b0;
        step(11);
        sw.lap = 1'b1; step(1); sw.lap = 1'b0;
        n_cmp++; if (sw.lap_out !== 7'd2 || sw.time_out !== 7'd3) begin
            n_bad++; $display("FAIL lap tick: got lap %0d time %0d want 2/3", sw.lap_out, sw.time_out);
        end
        step(8);
        sw.lap = 1'b1; sw.clear = 1'b1; step(1); sw.lap = 1'b0; sw.clear = 1'b0;
        n_cmp++; if (sw.lap_out !== 7'd5 || sw.time_out !== 7'd0 || sw.running !== 1'b1) begin
            n_bad++; $display("FAIL lap clear: got lap %0d time %0d run %b want 5/0/1", sw.lap_out, sw.time_out, sw.running);
        end
        step(4);
        n_cmp++; if (sw.time_out !== 7'd1) begin n_bad++; $display("FAIL lap restart: got %0d want 1", sw.time_out); end
        $display("test_lap complete");
    endtask

    task automatic test_back_to_back;
        step(1);
        sw.clear = 1'b1; sw.stop = 1'b1; sw.start = 1'b1; step(1);
        sw.clear = 1'b0; sw.stop = 1'b0; sw.start = 1'b0;
        n_cmp++; if (sw.time_out !== 7'd0 || sw.running !== 1'b0 || sw.done !== 1'b0) begin
            n_bad++; $display("FAIL b2b pulses: got time %0d run %b done %b want 0/0/0", sw.time_out, sw.running, sw.done);
        end
        step(8);
        n_cmp++; if (sw.time_out !== 7'd0) begin n_bad++; $display("FAIL b2b paused: got %0d want 0", sw.time_out); end
        sw.start = 1'b1; step(1); sw.start = 1'b0;
        step(3);
        n_cmp++; if (sw.time_out !== 7'd0 || sw.running !== 1'b1) begin
            n_bad++; $display("FAIL b2b resume: got time %0d run %b want 0/1", sw.time_out, sw.running);
        end
        step(1);
        n_cmp++; if (sw.time_out !== 7'd1) begin n_bad++; $display("FAIL b2b first: got %0d want 1", sw.time_out); end
        $display("test_back_to_back complete");
    endtask

    task automatic test_reset_mid;
        step(24);
        n_cmp++; if (sw.time_out !== 7'd7) begin n_bad++; $display("FAIL rstmid pre: got %0d want 7", sw.time_out); end
        rst = 1'b0; step(1);
        n_cmp++; if (sw.time_out !== 7'd0 || sw.lap_out !== 7'd0 || sw.running !== 1'b0 || sw.sec_tick !== 1'b0 || sw.done !== 1'b0) begin
            n_bad++; $display("FAIL rstmid outs: got time %0d lap %0d run %b tick %b done %b want all 0",
                              sw.time_out, sw.lap_out, sw.running, sw.sec_tick, sw.done);
        end
        rst = 1'b1; step(8);
        n_cmp++; if (sw.time_out !== 7'd0 || sw.running !== 1'b0) begin
            n_bad++; $display("FAIL rstmid idle: got time %0d run %b want 0/0", sw.time_out, sw.running);
        end
        $display("test_reset_mid complete");
    endtask

    task automatic test_limit_lower;
        sw.start = 1'b1; step(1); sw.start = 1'b0;
        step(20);
        n_cmp++; if (sw.time_out !== 7'd5) begin n_bad++; $display("FAIL lower pre: got %0d want 5", sw.time_out); end
        sw.limit = 7'd2; step(1);
        n_cmp++; if (sw.time_out !== 7'd5 || sw.done !== 1'b1 || sw.running !== 1'b0) begin
            n_bad++; $display("FAIL lower done: got time %0d done %b run %b want 5/1/0", sw.time_out, sw.done, sw.running);
        end
        step(6);
        n_cmp++; if (sw.time_out !== 7'd5) begin n_bad++; $display("FAIL lower hold: got %0d want 5", sw.time_out); end
        sw.clear = 1'b1; step(1); sw.clear = 1'b0; sw.limit = 7'd0;
        $display("test_limit_lower complete");
    endtask

    task automatic test_max_bcd;
        sw.limit = 7'd120;
        sw.start = 1'b1; step(1); sw.start = 1'b0;
        step(228);
        n_cmp++; if (sw.time_out !== 7'd57) begin n_bad++; $display("FAIL max 57: got %0d want 57", sw.time_out); end
`ifdef STOPWATCH_BCD_EN
        n_cmp++; if (sw.tens_out !== 4'd5 || sw.ones_out !== 4'd7) begin
            n_bad++; $display("FAIL bcd 57: got %0d%0d want 57", sw.tens_out, sw.ones_out);
        end
`endif
        step(167);
        n_cmp++; if (sw.time_out !== 7'd98 || sw.done !== 1'b0) begin
            n_bad++; $display("FAIL max 98: got time %0d done %b want 98/0", sw.time_out, sw.done);
        end
        step(1);
        n_cmp++; if (sw.time_out !== 7'd99 || sw.done !== 1'b1 || sw.running !== 1'b0) begin
            n_bad++; $display("FAIL max 99: got time %0d done %b run %b want 99/1/0", sw.time_out, sw.done, sw.running);
        end
`ifdef STOPWATCH_BCD_EN
        n_cmp++; if (sw.tens_out !== 4'd9 || sw.ones_out !== 4'd9) begin
            n_bad++; $display("FAIL bcd 99: got %0d%0d want 99", sw.tens_out, sw.ones_out);
        end
`endif
        step(8);
        n_cmp++; if (sw.time_out !== 7'd99) begin n_bad++; $display("FAIL max hold: got %0d want 99", sw.time_out); end
        $display("test_max_bcd complete");
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b0;
        sw.start = 1'b0;
        sw.stop  = 1'b0;
        sw.clear = 1'b0;
        sw.lap   = 1'b0;
        sw.limit = 7'd0;
        test_reset();
        test_count();
        test_pause();
        test_limit();
        test_lap();
        test_back_to_back();
        test_reset_mid();
        test_limit_lower();
        test_max_bcd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stopwatch.md
# stopwatch

Up-counting elapsed-seconds timer for the piano's practice/recording modes; the counterpart to the countdown timer. It counts whole seconds upward from zero on a clock-derived 1 s tick, supports start/pause/resume/clear and lap capture, and stops with a sticky `done` flag when a programmable limit is reached. Outputs feed the seven-segment display path and mode control FSMs.

## Interface
- `TICKS_PER_SEC`, default 100000000: `clk` cycles per counted second (≥2).
- `MAX_SEC`, default 99: hard ceiling on elapsed seconds (≤127).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle pulse; begin from IDLE or resume from PAUSE.
- `stop` in 1: one-cycle pulse; pause while in RUN.
- `clear` in 1: one-cycle pulse; zero the count and the done flag.
- `lap` in 1: one-cycle pulse; capture current `time_out` into `lap_out`.
- `limit` in 7: stop value in seconds; 0 or >MAX_SEC means MAX_SEC.
- `time_out` out 7: elapsed seconds.
- `lap_out` out 7: last captured lap value.
- `running` out 1: high in RUN.
- `sec_tick` out 1: one-cycle pulse on each increment.
- `done` out 1: sticky; high in DONE.

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset → IDLE.
- Reset values: `time_out`=0, `lap_out`=0, `running`=0, `sec_tick`=0, `done`=0, prescaler=0.
- Effective limit L = (`limit`==0 || `limit`>MAX_SEC) ? MAX_SEC : `limit`; evaluated every cycle.
- IDLE: `start` → RUN. `stop` ignored.
- RUN: prescaler counts 0..TICKS_PER_SEC-1. At terminal count: prescaler→0, `time_out`+1, `sec_tick`=1 for that one cycle. If the new value equals L: → DONE. If `time_out` ≥ L at any cycle (limit lowered mid-run): → DONE next cycle, `time_out` unchanged. `stop` → PAUSE.
- PAUSE: prescaler and `time_out` hold (fractional second kept). `start` → RUN, counting continues from the held prescaler value.
- DONE: `time_out` holds at L; `start`/`stop` ignored; only `clear` exits.
- `clear`: `time_out`=0, prescaler=0, `done`=0. From DONE or PAUSE → IDLE; from RUN stays RUN (restarts from zero); from IDLE stays IDLE.
- `lap`: accepted in any state; `lap_out` gets the registered `time_out` of the pulse cycle (pre-increment value if a tick coincides).
- Priority on simultaneous pulses: `rst` > `clear` > `stop` > `start`. `lap` is independent; with `clear` it captures the pre-clear value.
- `time_out` never exceeds MAX_SEC and never wraps.

## Timing
- All outputs registered; no combinational input-to-output path.
- `start` sampled at edge N → `running`=1 after edge N; the first increment occurs TICKS_PER_SEC edges after N.
- `stop` at edge N → `running`=0 after edge N; a tick due on edge N is suppressed.
- `sec_tick` asserts on the same edge that updates `time_out`.
- `done` and `running`=0 assert on the same edge that `time_out` reaches L.
- `lap_out` updates one edge after the `lap` pulse is sampled.

## Configuration
- `STOPWATCH_BCD_EN` defined: adds output ports `tens_out` (4) and `ones_out` (4), the registered BCD digits of `time_out`. They update on the same edge as `time_out` and reset to 0; values above 99 show tens=9, ones=9.
- Not defined: these ports and their logic are absent; the rest of the behaviour is identical.

## Test plan
- TICKS_PER_SEC=4, `limit`=0: reset, then `start` → `time_out` 1,2,3 at 4,8,12 cycles after `start`, one `sec_tick` per step, `running`=1.
- RUN, `stop` 2 cycles into a second, wait 20 cycles, `start` → `time_out` frozen while paused; next increment 2 cycles after resume.
- `limit`=3: `start` → `time_out`=3, `done`=1, `running`=0 on the same edge; further `start` has no effect; `clear` → 0, IDLE.
- `lap` on the same cycle as the 2→3 tick → `lap_out`=2, `time_out`=3; `lap`+`clear` at 5 → `lap_out`=5, `time_out`=0.
- `clear`, `stop`, and `start` in the same RUN cycle → count zeroed, PAUSE entered; `rst` low mid-RUN at `time_out`=7 → all outputs 0, IDLE.
- Limit lowered to 2 while `time_out`=5 in RUN → DONE next cycle with `time_out`=5; with the macro defined, `time_out`=57 gives `tens_out`=5, `ones_out`=7.
